// File: rtl/boneless_ext_pkg.sv
// Shared types for the Boneless external-bus arbiter: bus word width,
// debug FSM states and read-owner tag.
package boneless_ext_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/boneless_ext_arbiter.sv
// Shares the Boneless CPU external bus with a debug port. The CPU always wins
// combinationally; debug requests slip into idle cycles, one at a time.
module boneless_ext_arbiter
  import boneless_ext_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cpu_ext_adr,
  input  logic              cpu_ext_re,
  input  logic              cpu_ext_we,
  input  logic [WORD_W-1:0] cpu_ext_dat_w,
  output logic [WORD_W-1:0] cpu_ext_dat_r,
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [WORD_W-1:0] dbg_adr,
  input  logic [WORD_W-1:0] dbg_dat_w,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [WORD_W-1:0] dbg_dat_r,
  output logic              dbg_starved,
  output logic [WORD_W-1:0] ext_adr,
  output logic [WORD_W-1:0] ext_dat_w,
  output logic              ext_re,
  output logic              ext_we,
  input  logic [WORD_W-1:0] ext_dat_r
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t            r_state;
  owner_t            r_owner;
  logic [WORD_W-1:0] r_ext_adr;
  logic [WORD_W-1:0] r_ext_dat_w;
  logic [WORD_W-1:0] r_cpu_hold;
  logic [WORD_W-1:0] r_dbg_dat_r;
  logic [7:0]        r_wait_cnt;
  logic              r_starved;

  logic              w_cpu_act;
  logic              w_accept;
  logic [7:0]        w_wait_nxt;

  assign w_cpu_act = cpu_ext_re | cpu_ext_we;
  // Acceptance is masked during reset so dbg_ready reads 0 while rst is high.
  assign w_accept  = !rst && (r_state == ST_IDLE) && dbg_valid && !w_cpu_act;

  always_comb begin
    ext_adr   = r_ext_adr;
    ext_dat_w = r_ext_dat_w;
    ext_re    = 1'b0;
    ext_we    = 1'b0;
    if (w_cpu_act) begin
      ext_adr   = cpu_ext_adr;
      ext_dat_w = cpu_ext_dat_w;
      ext_re    = cpu_ext_re;
      ext_we    = cpu_ext_we;
    end else if (w_accept) begin
      ext_adr   = dbg_adr;
      ext_dat_w = dbg_dat_w;
      ext_re    = !dbg_we;
      ext_we    = dbg_we;
    end
  end

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!dbg_valid || w_accept) begin
      w_wait_nxt = '0;
    end else if (r_state == ST_IDLE && r_wait_cnt != 8'hFF) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_CPU;
      r_ext_adr   <= '0;
      r_ext_dat_w <= '0;
      r_cpu_hold  <= '0;
      r_dbg_dat_r <= '0;
      r_wait_cnt  <= '0;
      r_starved   <= 1'b0;
    end else begin
      r_ext_adr   <= ext_adr;
      r_ext_dat_w <= ext_dat_w;
      r_wait_cnt  <= w_wait_nxt;
      r_starved   <= (w_wait_nxt >= LIMIT);
      if (cpu_ext_re) begin
        r_owner <= OWN_CPU;
      end else if (w_accept && !dbg_we) begin
        r_owner <= OWN_DBG;
      end
      if (r_owner == OWN_CPU) begin
        r_cpu_hold <= ext_dat_r;
      end
      case (r_state)
        ST_IDLE:    if (w_accept && !dbg_we) r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_dbg_dat_r <= ext_dat_r;
          r_state     <= ST_RD_RESP;
        end
        ST_RD_RESP: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ext_dat_r = (r_owner == OWN_CPU) ? ext_dat_r : r_cpu_hold;
  assign dbg_ready     = w_accept;
  assign dbg_rvalid    = (r_state == ST_RD_RESP);
  assign dbg_dat_r     = r_dbg_dat_r;
  assign dbg_starved   = r_starved;

endmodule

// File: tb/tb_boneless_ext_arbiter.sv
// Bench for boneless_ext_arbiter: vector table for bus priority, hand-written
// sequences for reads, starvation and reset abort, scoreboard for debug reads.
module tb_boneless_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_ext_adr, cpu_ext_dat_w, cpu_ext_dat_r;
  logic        cpu_ext_re, cpu_ext_we;
  logic        dbg_valid, dbg_we, dbg_ready, dbg_rvalid, dbg_starved;
  logic [15:0] dbg_adr, dbg_dat_w, dbg_dat_r;
  logic [15:0] ext_adr, ext_dat_w;
  logic        ext_re, ext_we;
  logic [15:0] ext_dat_r = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } sb_t;
  sb_t sb[$];

  logic [15:0] mem [256];

  boneless_ext_arbiter #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_ext_adr(cpu_ext_adr), .cpu_ext_re(cpu_ext_re), .cpu_ext_we(cpu_ext_we),
    .cpu_ext_dat_w(cpu_ext_dat_w), .cpu_ext_dat_r(cpu_ext_dat_r),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_dat_w(dbg_dat_w),
    .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_dat_r(dbg_dat_r),
    .dbg_starved(dbg_starved),
    .ext_adr(ext_adr), .ext_dat_w(ext_dat_w), .ext_re(ext_re), .ext_we(ext_we),
    .ext_dat_r(ext_dat_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ext_re) ext_dat_r <= mem[ext_adr[7:0]];
    if (ext_we) mem[ext_adr[7:0]] <= ext_dat_w;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dbg_rvalid) begin
      if (sb.size() == 0) begin
        chk("rvalid_unexpected", 32'(dbg_rvalid), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("rvalid_data", 32'(dbg_dat_r), 32'(e.data));
        chk("rvalid_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_in(input logic cre, input logic cwe, input logic [15:0] cadr,
                        input logic [15:0] cdat, input logic dv, input logic dwe,
                        input logic [15:0] dadr, input logic [15:0] ddat);
    cpu_ext_re = cre; cpu_ext_we = cwe; cpu_ext_adr = cadr; cpu_ext_dat_w = cdat;
    dbg_valid = dv; dbg_we = dwe; dbg_adr = dadr; dbg_dat_w = ddat;
  endtask

  task automatic bus_chk(input string tag, input logic re, input logic we,
                         input logic [15:0] adr, input logic [15:0] dw, input logic rdy);
    chk({tag, "_ext_re"}, 32'(ext_re), 32'(re));
    chk({tag, "_ext_we"}, 32'(ext_we), 32'(we));
    chk({tag, "_ext_adr"}, 32'(ext_adr), 32'(adr));
    chk({tag, "_ext_dat_w"}, 32'(ext_dat_w), 32'(dw));
    chk({tag, "_dbg_ready"}, 32'(dbg_ready), 32'(rdy));
  endtask

  // Idle-CPU debug read; checks acceptance and queues the expected response.
  task automatic dbg_read(input string tag, input logic [15:0] adr, input logic [15:0] exp);
    set_in(0, 0, 16'h0, 16'h0, 1, 0, adr, 16'h0);
    smp();
    chk({tag, "_ready"}, 32'(dbg_ready), 32'd1);
    chk({tag, "_re"}, 32'(ext_re), 32'd1);
    chk({tag, "_adr"}, 32'(ext_adr), 32'(adr));
    sb.push_back('{data: exp, cyc: cyc + 2});
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (3) tick();
  endtask

  typedef struct {
    logic        cre, cwe;
    logic [15:0] cadr, cdat;
    logic        dv, dwe;
    logic [15:0] dadr, ddat;
    logic        xre, xwe;
    logic [15:0] xadr, xdat;
    logic        rdy;
  } vec_t;
  vec_t vt[8];

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[8'h05] = 16'hBEEF;
    mem[8'h50] = 16'h1234;
    mem[8'h60] = 16'hAAAA;

    //          cre cwe cadr     cdat     dv dwe dadr     ddat     xre xwe xadr     xdat     rdy
    vt[0] = '{0, 1, 16'h0030, 16'h1111, 1, 1, 16'h0100, 16'h5A5A, 0, 1, 16'h0030, 16'h1111, 0};
    vt[1] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0100, 16'h5A5A, 0, 1, 16'h0100, 16'h5A5A, 1};
    vt[2] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0100, 16'h5A5A, 0};
    vt[3] = '{1, 0, 16'h0040, 16'h2222, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h2222, 0};
    vt[4] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h2222, 0};
    vt[5] = '{0, 1, 16'h0041, 16'h3333, 1, 1, 16'h0042, 16'h4444, 0, 1, 16'h0041, 16'h3333, 0};
    vt[6] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0042, 16'h4444, 0, 1, 16'h0042, 16'h4444, 1};
    vt[7] = '{1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'h0010, 16'h0000, 0};

    // reset state, with a debug request pending during reset
    rst = 1'b1;
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    smp();
    bus_chk("reset", 0, 0, 16'h0, 16'h0, 0);
    chk("reset_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("reset_starved", 32'(dbg_starved), 32'd0);
    chk("reset_dat_r", 32'(dbg_dat_r), 32'd0);
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_in(vt[i].cre, vt[i].cwe, vt[i].cadr, vt[i].cdat,
             vt[i].dv, vt[i].dwe, vt[i].dadr, vt[i].ddat);
      smp();
      bus_chk($sformatf("vec%0d", i), vt[i].xre, vt[i].xwe, vt[i].xadr, vt[i].xdat, vt[i].rdy);
      chk($sformatf("vec%0d_rvalid", i), 32'(dbg_rvalid), 32'd0);
      tick();
    end

    // deferred debug read 0x0020 goes out on the first CPU-idle cycle
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
    smp();
    bus_chk("defer_accept", 1, 0, 16'h0020, 16'h0, 1);
    sb.push_back('{data: 16'hA020, cyc: cyc + 2});
    tick();
    // RD_WAIT: a new request must not be accepted, nothing issued
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    smp();
    bus_chk("rdwait_block", 0, 0, 16'h0020, 16'h0, 0);
    tick();
    // RD_RESP: CPU read passes through
    set_in(1, 0, 16'h0011, 16'h0, 1, 0, 16'h0005, 16'h0);
    smp();
    bus_chk("rdresp_cpu", 1, 0, 16'h0011, 16'h0, 0);
    tick();
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    smp();
    bus_chk("beef_accept", 1, 0, 16'h0005, 16'h0, 1);
    sb.push_back('{data: 16'hBEEF, cyc: cyc + 2});
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (3) tick();

    // data written earlier through the arbiter reads back
    dbg_read("rb_dbgwr", 16'h0100, 16'h5A5A);
    dbg_read("rb_cpuwr", 16'h0041, 16'h3333);
    dbg_read("rb_dbgwr2", 16'h0042, 16'h4444);

    // CPU read data is held across a debug read
    set_in(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0);
    tick();
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0060, 16'h0);
    smp();
    chk("hold_c1_ready", 32'(dbg_ready), 32'd1);
    chk("hold_c1", 32'(cpu_ext_dat_r), 32'h1234);
    sb.push_back('{data: 16'hAAAA, cyc: cyc + 2});
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    for (int i = 2; i <= 4; i++) begin
      smp();
      chk($sformatf("hold_c%0d", i), 32'(cpu_ext_dat_r), 32'h1234);
      tick();
    end

    // starvation: 20 CPU cycles with a pending debug write
    for (int k = 0; k < 20; k++) begin
      set_in(1, 0, 16'h0080, 16'h0, 1, 1, 16'h0070, 16'h7777);
      smp();
      chk($sformatf("starve_rdy%0d", k), 32'(dbg_ready), 32'd0);
      chk($sformatf("starve_k%0d", k), 32'(dbg_starved), 32'(k >= 16));
      tick();
    end
    set_in(0, 0, 16'h0, 16'h0, 1, 1, 16'h0070, 16'h7777);
    smp();
    bus_chk("starve_accept", 0, 1, 16'h0070, 16'h7777, 1);
    chk("starve_at_ready", 32'(dbg_starved), 32'd1);
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    smp();
    chk("starve_cleared", 32'(dbg_starved), 32'd0);
    tick();

    // counter saturates rather than wrapping
    for (int k = 0; k < 300; k++) begin
      set_in(0, 1, 16'h0081, 16'h0, 1, 0, 16'h0090, 16'h0);
      smp();
      if (k == 255 || k == 256 || k == 260 || k == 299)
        chk($sformatf("sat_k%0d", k), 32'(dbg_starved), 32'd1);
      tick();
    end
    // request withdrawn before acceptance: no bus activity, counter clears
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0090, 16'h0);
    smp();
    bus_chk("cancel", 0, 0, 16'h0081, 16'h0, 0);
    tick();
    smp();
    chk("cancel_starved", 32'(dbg_starved), 32'd0);
    tick();

    // reset during RD_WAIT aborts the read
    set_in(0, 0, 16'h0, 16'h0, 1, 0, 16'h0005, 16'h0);
    smp();
    chk("abort_accept", 32'(dbg_ready), 32'd1);
    tick();
    set_in(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    rst = 1'b1;
    #1;
    bus_chk("abort_rst", 0, 0, 16'h0, 16'h0, 0);
    chk("abort_rst_dat_r", 32'(dbg_dat_r), 32'd0);
    chk("abort_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("abort_post%0d", i), 32'(dbg_rvalid), 32'd0);
      tick();
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boneless_ext_arbiter.md
BONELESS_EXT_ARBITER -- requirements
Module: boneless_ext_arbiter

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: number of consecutive deferred debug cycles after which dbg_starved asserts; legal range 1..255.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: ports clk and rst.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cpu_ext_adr  in  16  CPU external bus address.
REQ-006 cpu_ext_re / cpu_ext_we  in  1 each  CPU read / write strobes; never both high.
REQ-007 cpu_ext_dat_w  in  16  CPU write data.
REQ-008 cpu_ext_dat_r  out  16  CPU read data.
REQ-009 dbg_valid  in  1  debug request pending; held with its fields until accepted.
REQ-010 dbg_we  in  1  debug request is a write (1) or read (0).
REQ-011 dbg_adr / dbg_dat_w  in  16 each  debug address / write data.
REQ-012 dbg_ready  out  1  debug request accepted this cycle.
REQ-013 dbg_rvalid  out  1  one-cycle pulse: dbg_dat_r holds read result.
REQ-014 dbg_dat_r  out  16  registered debug read data.
REQ-015 dbg_starved  out  1  debug deferred for at least WAIT_LIMIT consecutive cycles.
REQ-016 ext_adr / ext_dat_w  out  16 each  shared bus address / write data.
REQ-017 ext_re / ext_we  out  1 each  shared bus strobes.
REQ-018 ext_dat_r  in  16  slave read data; valid the cycle after ext_re; held while ext_re low.

Function
REQ-019 CPU SHALL have absolute priority: when cpu_ext_re or cpu_ext_we is high, ext_* SHALL equal the CPU fields in the same cycle (combinational, zero latency).
REQ-020 FSM states IDLE, RD_WAIT, RD_RESP. dbg_ready SHALL be high only when state=IDLE, dbg_valid=1, cpu_ext_re=0 and cpu_ext_we=0.
REQ-021 On acceptance, ext_* SHALL carry the debug fields that cycle; write: stay IDLE; read: go to RD_WAIT.
REQ-022 RD_WAIT: capture ext_dat_r into dbg_dat_r, go to RD_RESP. RD_RESP: dbg_rvalid=1 for one cycle, return to IDLE. Read latency is 2 cycles from acceptance to the dbg_rvalid cycle.
REQ-023 No debug request SHALL be accepted in RD_WAIT or RD_RESP; one debug transaction outstanding at most.
REQ-024 CPU accesses in RD_WAIT/RD_RESP SHALL pass through unaffected; the RD_WAIT capture uses ext_dat_r from the debug read issued in the previous cycle.
REQ-025 Register last_rd_owner (CPU/DBG) updates on every issued read; cpu_ext_dat_r = ext_dat_r when owner=CPU, else cpu_hold (last CPU read data, captured each cycle owner=CPU).
REQ-026 When no access is issued, ext_re=ext_we=0 and ext_adr/ext_dat_w SHALL hold their previous values.
REQ-027 8-bit wait counter: increments (saturating at 255) each cycle dbg_valid=1 and dbg_ready=0 in IDLE; clears on dbg_ready or dbg_valid=0.
REQ-028 dbg_starved SHALL equal (wait counter >= WAIT_LIMIT), registered.
REQ-029 dbg_valid dropping before acceptance SHALL cancel the request without bus activity.

Reset
REQ-030 On rst: state=IDLE, ext_re=ext_we=0, ext_adr=ext_dat_w=0, dbg_dat_r=0, cpu_hold=0, last_rd_owner=CPU, wait counter=0, dbg_ready=dbg_rvalid=dbg_starved=0.
REQ-031 Reset mid-read (RD_WAIT/RD_RESP) SHALL abort; no dbg_rvalid pulse after reset release for the aborted read.

Structure
REQ-032 Package boneless_ext_pkg SHALL hold the FSM state enum, owner enum and 16-bit word width constant.
REQ-033 Single module; wait counter is inline (no sub-module).

Verification
REQ-034 CPU read adr=0x0010 while dbg_valid read adr=0x0020 -> ext_adr=0x0010 that cycle, dbg_ready=0; next idle cycle dbg_ready=1, ext_adr=0x0020.
REQ-035 Idle CPU, debug read adr=0x0005 with ext[5]=0xBEEF -> dbg_rvalid pulses 2 cycles after dbg_ready, dbg_dat_r=0xBEEF.
REQ-036 CPU read returns 0x1234, then debug read returns 0xAAAA -> cpu_ext_dat_r stays 0x1234 throughout.
REQ-037 CPU strobes continuously 20 cycles with dbg_valid=1, WAIT_LIMIT=16 -> dbg_starved rises after 16 deferred cycles, clears the cycle after dbg_ready.
REQ-038 Debug write adr=0x0100 data=0x5A5A accepted -> ext_we=1, ext_dat_w=0x5A5A same cycle; no dbg_rvalid.
REQ-039 rst asserted in RD_WAIT -> all outputs reset immediately; no dbg_rvalid afterwards.
